data_mem_responder: RTL and testbench

- Multi-cycle data-memory target for the RV32I core's load/store path; responder end of the load/store request interface.
- Accepts one request at a time over a valid/ready channel, waits a programmable latency, then commits stores with byte enables or returns sign/zero-extended load data.
- Flags misaligned, out-of-range and illegal-funct3 accesses with an error response instead of touching memory.
- Replaces the zero-latency data memory when the core is moved to a stallable memory interface.

---
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory target for the load/store path.
// Accepts one request at a time, waits LATENCY cycles, then commits a store
// with byte enables or returns a sign/zero-extended load result. Illegal
// accesses (bad funct3, misaligned, out of range) get an error response and
// never touch the array.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  cnt;
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_func3;

    logic        accept;
    logic        do_access;
    logic        func_ok;
    logic        align_ok;
    logic        legal;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   st_data;

    // Array contents deliberately survive rst.
    logic [31:0] mem [DEPTH];

    assign accept   = req_valid & req_ready;
    assign word_idx = cap_addr[AW+1:2];
    assign lane     = cap_addr[1:0];

    // State register; rst overrides every other transition.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs; the access fires on the last WAIT edge.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                    do_access  = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Legality of the captured request: funct3 class, alignment, range.
    always_comb begin
        func_ok  = 1'b0;
        align_ok = 1'b0;
        case (cap_func3)
            3'b000: begin func_ok = 1'b1;       align_ok = 1'b1;                end
            3'b001: begin func_ok = 1'b1;       align_ok = ~cap_addr[0];        end
            3'b010: begin func_ok = 1'b1;       align_ok = (cap_addr[1:0] == 2'b00); end
            3'b100: begin func_ok = ~cap_write; align_ok = 1'b1;                end
            3'b101: begin func_ok = ~cap_write; align_ok = ~cap_addr[0];        end
            default: begin func_ok = 1'b0;      align_ok = 1'b0;                end
        endcase
        legal = func_ok & align_ok & (cap_addr < BYTE_LIMIT);
    end

    // Load extraction: shift the selected lane down, then extend by funct3.
    always_comb begin
        rd_word   = mem[word_idx];
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = 32'd0;
        case (cap_func3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Store lane enables and data replicated across lanes so each enabled
    // byte picks up the right slice without a variable shift.
    always_comb begin
        be      = 4'b0000;
        st_data = cap_wdata;
        case (cap_func3)
            3'b000: begin
                be      = 4'b0001 << lane;
                st_data = {4{cap_wdata[7:0]}};
            end
            3'b001: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cap_wdata[15:0]}};
            end
            3'b010: begin
                be      = 4'b1111;
                st_data = cap_wdata;
            end
            default: begin
                be      = 4'b0000;
                st_data = cap_wdata;
            end
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_func3 <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_func3 <= req_func3;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (do_access) begin
                rsp_rdata <= (legal && !cap_write) ? load_data : 32'd0;
                rsp_err   <= ~legal;
            end else if (rsp_valid && rsp_ready) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Store commit; gated by rst so a cancelled store never lands.
    always_ff @(posedge clk) begin
        if (!rst && do_access && cap_write && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance for function,
// errors, backpressure and reset; one LATENCY=1 instance for throughput.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_1, req_ready_1, req_write_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic [2:0]  req_func3_1;
    logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [31:0] rsp_rdata_1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (rsp_valid_1 && rsp_ready_1) rq.push_back(rsp_rdata_1);

    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_func3(req_func3_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One transaction on dut with rsp_ready high; checks latency and returns
    // the response fields.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, output logic [31:0] rd, output logic er);
        int lat;
        int to;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_func3 = f;
        to = 0;
        while (!req_ready && to < 20) begin @(negedge clk); to++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'd2);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          acc[16];
    int          bad_int;
    logic        tput_to;

    initial begin
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_func3 = 0;
        rsp_ready = 1'b1;
        req_valid_1 = 0; req_write_1 = 0; req_addr_1 = 0; req_wdata_1 = 0; req_func3_1 = 0;
        rsp_ready_1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata",     rsp_rdata,      32'd0);
        chk("rst_err",       32'(rsp_err),   32'd0);

        // Word store then readback
        xact(1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        xact(0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("lw_10", rd, 32'hDEADBEEF);

        // Sub-word stores and extending loads
        xact(1, 32'h11, 32'h000000AA, 3'b000, rd, er);
        chk("sb_err", 32'(er), 32'd0);
        xact(1, 32'h12, 32'h00001234, 3'b001, rd, er);
        chk("sh_err", 32'(er), 32'd0);
        xact(0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("lw_merged", rd, 32'h1234AAEF);
        xact(0, 32'h11, 32'h0, 3'b000, rd, er);
        chk("lb_11", rd, 32'hFFFFFFAA);
        xact(0, 32'h11, 32'h0, 3'b100, rd, er);
        chk("lbu_11", rd, 32'h000000AA);
        xact(0, 32'h12, 32'h0, 3'b001, rd, er);
        chk("lh_12", rd, 32'h00001234);
        xact(0, 32'h13, 32'h0, 3'b000, rd, er);
        chk("lb_13", rd, 32'h00000012);
        xact(0, 32'h10, 32'h0, 3'b101, rd, er);
        chk("lhu_10", rd, 32'h0000AAEF);

        // Errors
        xact(0, 32'h13, 32'h0, 3'b010, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rd", rd, 32'd0);
        xact(1, 32'h14, 32'hCAFEF00D, 3'b010, rd, er);
        xact(1, 32'h15, 32'hFFFFFFFF, 3'b001, rd, er);
        chk("sh_mis_err", 32'(er), 32'd1);
        xact(0, 32'h14, 32'h0, 3'b010, rd, er);
        chk("lw_14_kept", rd, 32'hCAFEF00D);
        chk("lw_14_err", 32'(er), 32'd0);
        xact(0, 32'h1000, 32'h0, 3'b010, rd, er);
        chk("lw_oor_err", 32'(er), 32'd1);
        chk("lw_oor_rd", rd, 32'd0);
        xact(0, 32'hFFC, 32'h0, 3'b010, rd, er);
        chk("lw_last_err", 32'(er), 32'd0);
        xact(0, 32'h10, 32'h0, 3'b011, rd, er);
        chk("f3_011_err", 32'(er), 32'd1);
        xact(1, 32'h10, 32'h0, 3'b100, rd, er);
        chk("st_f3_100_err", 32'(er), 32'd1);
        xact(0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("lw_10_kept", rd, 32'h1234AAEF);

        // Backpressure
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h10; req_func3 = 3'b010;
        rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_valid0", 32'(rsp_valid), 32'd1);
        chk("bp_rdata0", rsp_rdata, 32'h1234AAEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1; req_write = 1; req_addr = 32'h10;
                req_wdata = 32'h0; req_func3 = 3'b010;
            end else begin
                req_valid = 0;
            end
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h1234AAEF);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);
        xact(0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("bp_ignored_st", rd, 32'h1234AAEF);

        // Reset mid-store
        xact(1, 32'h20, 32'h0, 3'b010, rd, er);
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h55555555; req_func3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_err",   32'(rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("mid_rst_novalid", 32'(rsp_valid), 32'd0);
        xact(0, 32'h20, 32'h0, 3'b010, rd, er);
        chk("mid_rst_lw20", rd, 32'h00000000);

        // Throughput on the LATENCY=1 instance: alternating SW/LW pairs
        tput_to = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int to;
            @(negedge clk);
            req_valid_1 = 1'b1;
            req_write_1 = (i % 2 == 0);
            req_addr_1  = 32'(4 * (i / 2));
            req_wdata_1 = 32'h13570000 | (32'(i / 2 + 1) * 32'h0101);
            req_func3_1 = 3'b010;
            to = 0;
            while (!req_ready_1 && to < 20) begin @(negedge clk); to++; end
            if (to >= 20) tput_to = 1'b1;
            acc[i] = cyc;
            @(posedge clk);
        end
        #1 req_valid_1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("tput_timeout", 32'(tput_to), 32'd0);
        bad_int = 0;
        for (int i = 1; i < 16; i++) if (acc[i] - acc[i-1] != 3) bad_int++;
        chk("tput_interval", 32'(bad_int), 32'd0);
        chk("tput_count", 32'(rq.size()), 32'd16);
        for (int i = 0; i < 16 && i < rq.size(); i++) begin
            if (i % 2 == 0) chk("tput_sw", rq[i], 32'd0);
            else            chk("tput_lw", rq[i], 32'h13570000 | (32'(i / 2 + 1) * 32'h0101));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
